// File: rtl/panel_switch_conditioner.sv
// Front-panel switch conditioner: per-bit debounce of the scanned switch matrix,
// stable toggle outputs and run-interlocked, prioritised one-cycle command pulses.
module panel_switch_conditioner #(
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_valid,
    input  logic [1:0]  scan_row,
    input  logic [11:0] scan_col,
    input  logic        run,
    output logic [11:0] sr,
    output logic [2:0]  dfsr,
    output logic [2:0]  ifsr,
    output logic        sing_step,
    output logic        sing_inst,
    output logic        start,
    output logic        load_addr,
    output logic        dep,
    output logic        exam,
    output logic        cont,
    output logic        stop
);

    logic [11:0] r0_s_q, r0_s_d;
    logic [11:0] r1_s_q, r1_s_d;
    logic [1:0]  r2_s_q, r2_s_d;
    logic [3:0]  r0_c_q [12];
    logic [3:0]  r0_c_d [12];
    logic [3:0]  r1_c_q [12];
    logic [3:0]  r1_c_d [12];
    logic [3:0]  r2_c_q [2];
    logic [3:0]  r2_c_d [2];
    logic [5:0]  cmd_q, cmd_d;
    logic [5:0]  press;

    // Returns {new stable value, new agreement count} for one switch bit.
    function automatic logic [4:0] debounce(input logic s, input logic smp, input logic [3:0] c);
        if (smp == s) begin
            return {s, 4'd0};
        end else if (int'(c) + 1 >= DEBOUNCE_SAMPLES) begin
            return {smp, 4'd0};
        end else begin
            return {s, c + 4'd1};
        end
    endfunction

    always_comb begin
        r0_s_d = r0_s_q;
        r1_s_d = r1_s_q;
        r2_s_d = r2_s_q;
        r0_c_d = r0_c_q;
        r1_c_d = r1_c_q;
        r2_c_d = r2_c_q;
        if (scan_valid) begin
            case (scan_row)
                2'd0: begin
                    for (int i = 0; i < 12; i++) begin
                        {r0_s_d[i], r0_c_d[i]} = debounce(r0_s_q[i], scan_col[i], r0_c_q[i]);
                    end
                end
                2'd1: begin
                    for (int i = 0; i < 12; i++) begin
                        {r1_s_d[i], r1_c_d[i]} = debounce(r1_s_q[i], scan_col[i], r1_c_q[i]);
                    end
                end
                2'd2: begin
                    for (int i = 0; i < 2; i++) begin
                        {r2_s_d[i], r2_c_d[i]} = debounce(r2_s_q[i], scan_col[10+i], r2_c_q[i]);
                    end
                end
                default: ;
            endcase
        end

        // Key bits 5..0 are start, load_addr, dep, exam, cont, stop; only stop bypasses run.
        press = r1_s_d[5:0] & ~r1_s_q[5:0];
        if (run) begin
            press = press & 6'b000001;
        end

        cmd_d = 6'd0;
        if (press[0])      cmd_d[0] = 1'b1;
        else if (press[5]) cmd_d[5] = 1'b1;
        else if (press[1]) cmd_d[1] = 1'b1;
        else if (press[4]) cmd_d[4] = 1'b1;
        else if (press[3]) cmd_d[3] = 1'b1;
        else if (press[2]) cmd_d[2] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_s_q <= '0;
            r1_s_q <= '0;
            r2_s_q <= '0;
            cmd_q  <= '0;
            for (int i = 0; i < 12; i++) begin
                r0_c_q[i] <= '0;
                r1_c_q[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                r2_c_q[i] <= '0;
            end
        end else begin
            r0_s_q <= r0_s_d;
            r1_s_q <= r1_s_d;
            r2_s_q <= r2_s_d;
            cmd_q  <= cmd_d;
            r0_c_q <= r0_c_d;
            r1_c_q <= r1_c_d;
            r2_c_q <= r2_c_d;
        end
    end

    assign sr        = r0_s_q;
    assign dfsr      = r1_s_q[11:9];
    assign ifsr      = r1_s_q[8:6];
    assign sing_step = r2_s_q[1];
    assign sing_inst = r2_s_q[0];
    assign start     = cmd_q[5];
    assign load_addr = cmd_q[4];
    assign dep       = cmd_q[3];
    assign exam      = cmd_q[2];
    assign cont      = cmd_q[1];
    assign stop      = cmd_q[0];

endmodule
